// File: rtl/md_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer: md op codes, FSM states,
// stall and divider-start constants, and small op-class helpers.
package md_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  localparam logic STOP      = 1'b1;
  localparam logic NO_STOP   = 1'b0;
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  function automatic logic is_mul(input logic [2:0] code);
    return (code == OP_MULT) || (code == OP_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] code);
    return (code == OP_DIV) || (code == OP_DIVU);
  endfunction

  function automatic logic is_md(input logic [2:0] code);
    return is_mul(code) || is_div(code);
  endfunction

endpackage

// File: rtl/md_hilo.sv
// Architectural HI/LO register pair with independent write enables and a
// shared 64-bit write port ({hi, lo}).
module md_hilo (
  input  logic        clk,
  input  logic        resetn,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [63:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (hi_we) hi <= wdata[63:32];
      if (lo_we) lo <= wdata[31:0];
    end
  end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer for EX: drives the external multiplier and divider,
// requests stalls while an op is in flight, and owns HI/LO.
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        pipe_stall,
  input  logic        flush,
  output logic        stallreq,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        op_done
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  md_state_e   state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [31:0] opa_q, opb_q;
  logic        sgn_q, done_q;
  logic        accept;
  logic        hi_we, lo_we;
  logic [63:0] wdata;

  // NOTE: every signal assigned here gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    accept    = 1'b0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    wdata     = '0;
    stallreq  = NO_STOP;
    div_start = DIV_STOP;
    div_annul = 1'b0;

    case (state)
      ST_IDLE: begin
        // Gated by resetn so the stall request is low while held in reset.
        if (resetn && op_valid && is_md(op_code)) stallreq = STOP;
        if (op_valid) begin
          if (is_mul(op_code)) begin
            accept   = 1'b1;
            cnt_nx   = CW'(MUL_LAT - 1);
            state_nx = ST_MUL;
          end else if (is_div(op_code)) begin
            accept = 1'b1;
            if (src_b != '0) begin
              state_nx = ST_DIV;
            end else begin
              hi_we    = 1'b1;
              lo_we    = 1'b1;
              wdata    = {src_a, 32'hFFFF_FFFF};
              state_nx = ST_DONE;
            end
          end else if (op_code == OP_MTHI) begin
            hi_we = 1'b1;
            wdata = {src_a, src_a};
          end else if (op_code == OP_MTLO) begin
            lo_we = 1'b1;
            wdata = {src_a, src_a};
          end
        end
      end
      ST_MUL: begin
        stallreq = STOP;
        if (cnt == '0) begin
          hi_we    = 1'b1;
          lo_we    = 1'b1;
          wdata    = mul_result;
          state_nx = ST_DONE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      ST_DIV: begin
        stallreq  = STOP;
        div_start = DIV_START;
        if (div_ready) begin
          hi_we    = 1'b1;
          lo_we    = 1'b1;
          wdata    = div_result;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        // Hold here while EX is stalled so the lingering op is not re-issued.
        if (!pipe_stall) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase

    // Flush overrides everything, including a same-cycle result capture.
    if (flush) begin
      state_nx = ST_IDLE;
      accept   = 1'b0;
      hi_we    = 1'b0;
      lo_we    = 1'b0;
      if (state == ST_DIV) begin
        div_annul = 1'b1;
        div_start = DIV_STOP;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      sgn_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      done_q <= (state_nx == ST_DONE) && (state != ST_DONE);
      if (accept) begin
        opa_q <= src_a;
        opb_q <= src_b;
        sgn_q <= (op_code == OP_MULT) || (op_code == OP_DIV);
      end
    end
  end

  assign mul_signed = sgn_q;
  assign mul_ina    = opa_q;
  assign mul_inb    = opb_q;
  assign div_signed = sgn_q;
  assign div_opa    = opa_q;
  assign div_opb    = opb_q;
  assign op_done    = done_q;

  md_hilo u_hilo (
    .clk    (clk),
    .resetn (resetn),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .hi     (hi),
    .lo     (lo)
  );

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl with multiplier/divider stubs, a result
// scoreboard, a vector table and hand-written corner-case sequences.
module tb_md_ctrl;
  import md_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] src_a, src_b;
  logic        pipe_stall, ext_stall, flush;
  logic        stallreq, mul_signed, div_start, div_signed, div_annul, div_ready, op_done;
  logic [31:0] mul_ina, mul_inb, div_opa, div_opb, hi, lo;
  logic [63:0] mul_prod, div_result;
  logic [63:0] mul_result = '0;
  int          div_lat = 1;
  int          ds_cnt = 0;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  md_ctrl #(.MUL_LAT(2)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .op_valid   (op_valid),
    .op_code    (op_code),
    .src_a      (src_a),
    .src_b      (src_b),
    .pipe_stall (pipe_stall),
    .flush      (flush),
    .stallreq   (stallreq),
    .mul_signed (mul_signed),
    .mul_ina    (mul_ina),
    .mul_inb    (mul_inb),
    .mul_result (mul_result),
    .div_start  (div_start),
    .div_signed (div_signed),
    .div_annul  (div_annul),
    .div_opa    (div_opa),
    .div_opb    (div_opb),
    .div_result (div_result),
    .div_ready  (div_ready),
    .hi         (hi),
    .lo         (lo),
    .op_done    (op_done)
  );

  // Stall controller: EX stalls on our own request or an external hold.
  always_comb pipe_stall = stallreq | ext_stall;

  // Multiplier stub: one register stage, sign-extended when signed.
  always_comb begin
    if (mul_signed)
      mul_prod = {{32{mul_ina[31]}}, mul_ina} * {{32{mul_inb[31]}}, mul_inb};
    else
      mul_prod = {32'b0, mul_ina} * {32'b0, mul_inb};
  end
  always @(posedge clk) mul_result <= mul_prod;

  // Divider stub: ready after div_lat cycles of div_start.
  always @(posedge clk) ds_cnt <= div_start ? ds_cnt + 1 : 0;
  assign div_ready = div_start && (ds_cnt == div_lat - 1);
  always_comb begin
    div_result = '0;
    if (div_opb != '0) begin
      if (div_signed)
        div_result = {32'($signed(div_opa) % $signed(div_opb)),
                      32'($signed(div_opa) / $signed(div_opb))};
      else
        div_result = {div_opa % div_opb, div_opa / div_opb};
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op, model EX holding it until not stalled, count stall/start
  // cycles and op_done pulses; op_done pops and checks the scoreboard.
  task automatic run_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int hold,
                        output int stall_n, output int ds_n, output int done_n);
    int cyc, post, held;
    bit left;
    logic [63:0] exp;
    stall_n = 0; ds_n = 0; done_n = 0;
    cyc = 0; post = 0; held = 0; left = 1'b0;
    div_lat = lat;
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = code; src_a = a; src_b = b;
    while (post < 3) begin
      @(negedge clk);
      if (stallreq)  stall_n++;
      if (div_start) ds_n++;
      if (op_done) begin
        done_n++;
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_op_done: got pulse expected none");
        end else begin
          exp = sb.pop_front();
          check("hi", {32'b0, hi}, {32'b0, exp[63:32]});
          check("lo", {32'b0, lo}, {32'b0, exp[31:0]});
        end
        if (hold > 0) ext_stall = 1'b1;
      end else if (ext_stall) begin
        held++;
        if (held >= hold) ext_stall = 1'b0;
      end
      if (left) post++;
      else if (!(stallreq || ext_stall)) left = 1'b1;
      cyc++;
      if (cyc > 300) begin
        total++; bad++;
        $display("FAIL op_timeout: got no completion expected completion within 300 cycles");
        break;
      end
      @(posedge clk); #1;
      if (left) op_valid = 1'b0;
    end
  endtask

  typedef struct {
    logic [2:0]  code;
    logic [31:0] a, b, hi, lo;
    int          lat, stall, dstart;
  } vec_t;

  vec_t vecs[7];
  int sn, dn, don;

  initial begin
    vecs[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1, 3, 0};
    vecs[1] = '{OP_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 1, 3, 0};
    vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 34, 33};
    vecs[3] = '{OP_DIVU,  32'h0000_0055, 32'd0, 32'h0000_0055, 32'hFFFF_FFFF, 1, 1, 0};
    vecs[4] = '{OP_DIVU,  32'd100,       32'd7, 32'h0000_0002, 32'h0000_000E, 5, 6, 5};
    vecs[5] = '{OP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1, 3, 0};
    vecs[6] = '{OP_DIV,   32'h8000_0000, 32'd3, 32'hFFFF_FFFE, 32'hD555_5556, 4, 5, 4};

    resetn = 1'b0; op_valid = 1'b0; op_code = '0; src_a = '0; src_b = '0;
    ext_stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);
    check("rst_ctl", {59'b0, stallreq, op_done, div_start, div_annul, div_signed}, 64'd0);
    check("rst_ops", {mul_ina | div_opa, mul_inb | div_opb}, 64'd0);
    resetn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      sb.push_back({vecs[i].hi, vecs[i].lo});
      run_op(vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].lat, 0, sn, dn, don);
      check($sformatf("v%0d_stall_cycles", i), 64'(sn), 64'(vecs[i].stall));
      check($sformatf("v%0d_div_start_cycles", i), 64'(dn), 64'(vecs[i].dstart));
      check($sformatf("v%0d_op_done_pulses", i), 64'(don), 64'd1);
    end

    // MULT completing under a 3-cycle pipe_stall hold in DONE.
    sb.push_back({32'd0, 32'd30});
    run_op(OP_MULT, 32'd5, 32'd6, 1, 3, sn, dn, don);
    check("hold_stall_cycles", 64'(sn), 64'd3);
    check("hold_op_done_pulses", 64'(don), 64'd1);

    run_op(OP_MTHI, 32'h0000_1234, 32'd0, 1, 0, sn, dn, don);
    check("mthi_hi", {32'b0, hi}, 64'h1234);
    check("mthi_lo_kept", {32'b0, lo}, 64'd30);
    check("mthi_stall", 64'(sn), 64'd0);
    run_op(OP_MTLO, 32'h0000_ABCD, 32'd0, 1, 0, sn, dn, don);
    check("mtlo_lo", {32'b0, lo}, 64'hABCD);
    check("mtlo_done", 64'(don), 64'd0);
    run_op(3'd6, 32'hDEAD_BEEF, 32'd1, 1, 0, sn, dn, don);
    check("unknown_op_hilo", {hi, lo}, {32'h1234, 32'hABCD});
    check("unknown_op_stall", 64'(sn + don), 64'd0);

    // Flush in DIV cycle 10.
    div_lat = 40;
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = OP_DIV; src_a = 32'd100; src_b = 32'd3;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_annul", {63'b0, div_annul}, 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    check("flush_after_ctl", {61'b0, stallreq, div_annul, div_start}, 64'd0);
    check("flush_hilo_kept", {hi, lo}, {32'h1234, 32'hABCD});
    check("flush_no_done", {63'b0, op_done}, 64'd0);

    // Back to IDLE: a following op still runs normally.
    sb.push_back({32'd2, 32'hE});
    run_op(OP_DIVU, 32'd100, 32'd7, 3, 0, sn, dn, don);
    check("post_flush_stall", 64'(sn), 64'd4);

    // Async reset in the middle of a divide.
    div_lat = 40;
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = OP_DIV; src_a = 32'hFFFF_FFF9; src_b = 32'd2;
    repeat (5) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midrst_ctl", {59'b0, stallreq, op_done, div_start, div_annul, div_signed}, 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    check("midrst_ops", {div_opa | mul_ina, div_opb | mul_inb}, 64'd0);
    @(negedge clk);
    op_valid = 1'b0;
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Multiply/divide sequencer for the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and drives the multi-cycle multiplier and the iterative divider. It raises the EX stall request while an operation is in flight and owns the architectural HI/LO registers. It sits beside the ALU and replaces the ad-hoc divide control inside EX.

## Interface
Parameters:
- MUL_LAT, 2: cycles from multiplier operands stable to `mul_result` valid (≥1).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- op_valid  in  1  EX holds an md op; held stable while stalled.
- op_code  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; others no-op.
- src_a, src_b  in  32 each  rs / rt operands.
- pipe_stall  in  1  EX cannot advance this cycle (stall[3]).
- flush  in  1  annul the in-flight op.
- stallreq  out  1  stall request to the stall controller.
- mul_signed  out  1  signed-multiply select.
- mul_ina, mul_inb  out  32 each  multiplier operands.
- mul_result  in  64  multiplier product.
- div_start  out  1  divider start.
- div_signed  out  1  signed-divide select.
- div_annul  out  1  divider annul.
- div_opa, div_opb  out  32 each  dividend, divisor.
- div_result  in  64  {remainder, quotient}.
- div_ready  in  1  divider result valid.
- hi, lo  out  32 each  architectural HI/LO.
- op_done  out  1  one-cycle pulse when a MUL/DIV result is committed.

## Operation
- FSM states: IDLE, MUL, DIV, DONE. Encodings live in a shared constant.
- **IDLE, op_valid with MULT/MULTU**
  - Latch operands and signedness.
  - Counter ← MUL_LAT-1.
  - Next state MUL.
- **IDLE, op_valid with DIV/DIVU**
  - Latch operands and signedness.
  - If src_b ≠ 0: next state DIV.
  - If src_b = 0: no divider start; hi←src_a, lo←32'hFFFFFFFF; next state DONE.
- **IDLE, MTHI/MTLO**
  - hi or lo ← src_a at the edge. No stall. Stay in IDLE.
- **stallreq (combinational)**
  - Asserted in IDLE while op_valid carries a MUL/DIV op.
  - Asserted throughout MUL.
  - Asserted in DIV until the cycle div_ready=1, inclusive.
  - Deasserted in DONE.
- **MUL**
  - mul_ina/inb/signed are driven from latched registers.
  - Counter decrements each cycle.
  - At counter=0: {hi,lo}←mul_result; next state DONE.
- **DIV**
  - div_start=1 and latched operands are held every cycle until div_ready.
  - On div_ready: hi←div_result[63:32], lo←div_result[31:0]; next state DONE.
- **DONE**
  - op_done=1 on the first DONE cycle only.
  - Stays in DONE while pipe_stall=1, so the still-present op_valid is not re-issued.
  - Goes to IDLE on the first cycle pipe_stall=0.
- **flush**
  - Any state → IDLE at the edge. HI/LO are not written.
  - If flushed in DIV: div_annul=1 for that cycle.
  - Flush coinciding with div_ready or counter=0: flush wins, no write.
- **Ignored inputs**
  - op_valid/op_code changes in MUL/DIV.
  - Unknown op_code in IDLE (no state change).
- **Arithmetic**
  - Products and quotients come from the external units unchanged.
  - Divide-by-zero gives the defined value above.

## Timing
- **Reset:** state IDLE, hi=lo=0, and every output 0: stallreq, op_done, mul_signed, mul_ina, mul_inb, div_start, div_signed, div_opa, div_opb, div_annul.
- **MUL (MUL_LAT=2):**
  - Accept in cycle 0; MUL in cycles 1–2; capture at the end of cycle 2.
  - stallreq high in cycles 0–2 (MUL_LAT+1 cycles).
  - hi/lo and op_done visible in cycle 3.
- **DIV:**
  - Accept in cycle 0; div_start from cycle 1.
  - If div_ready arrives in cycle k, stallreq is high in cycles 0..k.
  - hi/lo are updated and op_done=1 in cycle k+1.
- **Divide-by-zero:** stallreq high in cycle 0 only; op_done in cycle 1.
- **MTHI/MTLO:** the register updates at the end of cycle 0.
- **Back-to-back ops:** a new op is accepted one cycle after DONE→IDLE at the earliest.
- **Async reset mid-op:** immediate return to the reset values; the divider sees div_start=0.

## Structure
- **Shared defines (defines.vh):**
  - md op_code encodings.
  - FSM state encodings.
  - Stop/NoStop and DivStart/DivStop constants.
- **Sub-module md_hilo:**
  - HI/LO register pair with separate hi/lo write enables and a 64-bit write port.
  - Async active-low reset.

## Test plan
- MULT 0xFFFFFFFE×3 → hi=FFFFFFFF, lo=FFFFFFFA; stallreq high exactly 3 cycles; one op_done pulse.
- MULTU 0xFFFFFFFE×3 → hi=00000002, lo=FFFFFFFA.
- DIV −7/2, divider stub with div_ready in cycle 33 → lo=FFFFFFFD, hi=FFFFFFFF; stallreq high in cycles 0–33.
- DIVU 0x55/0 → div_start never asserted; hi=00000055, lo=FFFFFFFF; stallreq high 1 cycle.
- Flush in DIV cycle 10 → div_annul high 1 cycle; state IDLE; hi/lo unchanged; stallreq low next cycle.
- MULT completes with pipe_stall held 3 cycles in DONE → no re-issue, single op_done. Then MTHI 0x1234 → hi=00001234 next cycle with no stallreq. resetn low mid-DIV → all outputs 0 immediately.
